div32_seq: RTL

DIV32_SEQ -- requirements
Module: div32_seq

---
 rtl/div32_pkg.sv | 7 +
 rtl/div32_step.sv | 14 +
 rtl/div32_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/div32_pkg.sv
// div32_pkg: shared types and constants for the sequential 32-bit divider
package div32_pkg;
  localparam int WIDTH = 32;
  localparam int STEPS = 32;
  localparam logic [WIDTH-1:0] DZ_QUOT = '1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div32_step.sv
// div32_step: one combinational restoring shift-subtract step
module div32_step
  import div32_pkg::*;
(
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] diff;
  assign diff     = shifted - {1'b0, divisor};
  assign q_bit    = shifted >= {1'b0, divisor};
  assign rem_next = q_bit ? diff : shifted;
endmodule

// File: rtl/div32_seq.sv
// div32_seq: sequential restoring divider, 32 steps; DIV_SIGNED_EN adds signed_op for two's-complement mode
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div32_pkg::state_t, div32_pkg::IDLE, div32_pkg::RUN, div32_pkg::DONE;
  import div32_pkg::STEPS, div32_pkg::DZ_QUOT;
  state_t state;
  logic [5:0] cnt;
  logic [WIDTH:0] rem, rem_nx;
  logic [WIDTH-1:0] quo, dvs, a_mag, b_mag;
  logic neg_q, neg_r, dz, q_bit, sa, sb, zero_div;
`ifdef DIV_SIGNED_EN
  assign sa = signed_op & dividend[WIDTH-1];
  assign sb = signed_op & divisor[WIDTH-1];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  assign zero_div = divisor == '0;
  assign a_mag = sa ? -dividend : dividend;
  assign b_mag = sb ? -divisor : divisor;
  // quo holds the remaining dividend bits and collects quotient bits at the LSB
  div32_step u_step (
    .shifted  ((WIDTH+1)'({rem, quo[WIDTH-1]})),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
    end else begin
      done <= state == DONE;
      if (done) busy <= 1'b0;
      case (state)
        IDLE: if (start && !busy) begin
          busy  <= 1'b1;
          cnt   <= '0;
          dz    <= zero_div;
          neg_q <= !zero_div && (sa ^ sb);
          neg_r <= !zero_div && sa;
          quo   <= zero_div ? DZ_QUOT : a_mag;
          rem   <= zero_div ? {1'b0, dividend} : '0;
          dvs   <= b_mag;
          state <= zero_div ? DONE : RUN;
        end
        RUN: begin
          quo   <= {quo[WIDTH-2:0], q_bit};
          rem   <= rem_nx;
          cnt   <= cnt == 6'(STEPS-1) ? '0 : cnt + 6'd1;
          state <= cnt == 6'(STEPS-1) ? DONE : RUN;
        end
        DONE: begin
          quotient    <= neg_q ? -quo : quo;
          remainder   <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          div_by_zero <= dz;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
